opb_register_simulink2ppc_snap: RTL and testbench

//  OPB slave that lets PPC software read values produced by Simulink user logic.
//  It is the read-back counterpart of the ppc2simulink software-control register.
//  It captures user_data_in on user_valid and keeps a status/overflow flag and a capture count.

---
 rtl/opb_register_simulink2ppc_snap.sv | 124 ++++++++++++
 tb/tb_opb_register_simulink2ppc_snap.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave that lets PPC software read a snapshot of Simulink user data:
// the last captured value, NEW/OVF/FREEZE status, a freeze control and a capture count.
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h01004300,
    parameter logic [31:0] C_HIGHADDR   = 32'h010043FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid
);

    localparam string unused_family = C_FAMILY;

    // Transfer handshake: a hit in IDLE is acked for exactly one cycle (ACK),
    // then WAIT holds off until OPB_select drops, so each select gets one ack.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        hit, cap, ack_cyc;
    logic [1:0]  widx;
    logic [31:0] rd_val, rd_q, data_q, count_q, count_d;
    logic        new_q, ovf_q, freeze_q;
    logic        rnw_q, be3_q;
    logic [1:0]  widx_q, wbits_q;
    logic        data_rd_clr, ovf_clr, ctrl_wr;
    logic        unused_sink;

    assign unused_sink = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:C_OPB_DWIDTH-3]};

    assign hit  = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign widx = OPB_ABus[C_OPB_AWIDTH-4:C_OPB_AWIDTH-3];
    assign cap  = user_valid && !freeze_q;

    assign ack_cyc     = (state_q == ACK);
    assign data_rd_clr = ack_cyc && rnw_q && (widx_q == 2'd0);
    assign ovf_clr     = ack_cyc && !rnw_q && (widx_q == 2'd1) && wbits_q[1];
    assign ctrl_wr     = ack_cyc && !rnw_q && (widx_q == 2'd2) && be3_q;

    assign count_d = cap ? count_q + 32'd1 : count_q;

    always_comb begin
        rd_val = '0;
        case (widx)
            2'd0:    rd_val = data_q;
            2'd1:    rd_val = {29'd0, freeze_q, ovf_q, new_q};
            2'd2:    rd_val = {31'd0, freeze_q};
            default: rd_val = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit) state_d = ACK;
            ACK:     state_d = WAIT;
            WAIT:    if (!OPB_select) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q  <= IDLE;
            rnw_q    <= 1'b0;
            be3_q    <= 1'b0;
            widx_q   <= 2'd0;
            wbits_q  <= 2'd0;
            rd_q     <= '0;
            data_q   <= '0;
            count_q  <= '0;
            new_q    <= 1'b0;
            ovf_q    <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && hit) begin
                rnw_q   <= OPB_RNW;
                be3_q   <= OPB_BE[3];
                widx_q  <= widx;
                wbits_q <= {OPB_DBus[C_OPB_DWIDTH-2], OPB_DBus[C_OPB_DWIDTH-1]};
                rd_q    <= rd_val;
            end
            if (cap) data_q <= user_data_in;
            count_q <= count_d;
            // A capture in the same cycle as a DATA read or OVF clear always wins.
            new_q   <= cap | (new_q & ~data_rd_clr);
            ovf_q   <= (cap & new_q) | (ovf_q & ~ovf_clr);
            if (ctrl_wr) freeze_q <= wbits_q[0];
        end
    end

    // OPB numbers bits MSB-first, so bus bit i carries register bit 31-i.
    always_comb begin
        Sl_DBus = '0;
        if (ack_cyc && rnw_q) begin
            for (int i = 0; i < 32; i++) Sl_DBus[i] = rd_q[31-i];
        end
    end

    assign Sl_xferAck = ack_cyc;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Bench for opb_register_simulink2ppc_snap: rule-level register model checked every
// cycle, plus directed transfers with hand-computed literal expectations.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h01004300;
    localparam logic [31:0] HIGH = 32'h010043FF;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [0:31] abus = '0;
    logic [0:31] dbus = '0;
    logic [0:3]  be   = '0;
    logic        rnw  = 1'b0;
    logic        sel  = 1'b0;
    logic        seq  = 1'b0;
    logic [31:0] ud   = '0;
    logic        uv   = 1'b0;
    logic [0:31] sl_dbus;
    logic        sl_ack, sl_err, sl_retry, sl_tout;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    bit preload_req = 1'b0;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seq),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (sl_ack),
        .Sl_errAck    (sl_err),
        .Sl_retry     (sl_retry),
        .Sl_toutSup   (sl_tout),
        .user_data_in (ud),
        .user_valid   (uv)
    );

    function automatic logic [31:0] bus2reg(input logic [0:31] b);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31-i] = b[i];
        return r;
    endfunction

    function automatic logic [0:31] reg2bus(input logic [31:0] r);
        logic [0:31] b;
        for (int i = 0; i < 32; i++) b[i] = r[31-i];
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Rule-level model: register contents, plus which transfer is being acked and
    // the word value it must return (snapshot taken when the transfer is accepted).
    logic [31:0] m_data, m_count, m_exp_rd;
    logic        m_new, m_ovf, m_freeze;
    logic        m_acked, m_exp_ack, m_rnw, m_be3, m_w1, m_w0;
    logic [1:0]  m_idx;
    logic        m_cap, m_hit, m_start, m_rd_clr, m_ovf_clr, m_ctrl_wr;
    logic [1:0]  a_idx;

    function automatic logic [31:0] word_view(input logic [1:0] i);
        case (i)
            2'd0:    return m_data;
            2'd1:    return {29'd0, m_freeze, m_ovf, m_new};
            2'd2:    return {31'd0, m_freeze};
            default: return m_count;
        endcase
    endfunction

    assign a_idx     = abus[28:29];
    assign m_cap     = uv && !m_freeze;
    assign m_hit     = sel && (abus >= BASE) && (abus <= HIGH);
    assign m_start   = m_hit && !m_acked;
    assign m_rd_clr  = m_exp_ack && m_rnw && (m_idx == 2'd0);
    assign m_ovf_clr = m_exp_ack && !m_rnw && (m_idx == 2'd1) && m_w1;
    assign m_ctrl_wr = m_exp_ack && !m_rnw && (m_idx == 2'd2) && m_be3;

    always @(posedge clk) begin
        if (rst) begin
            m_data <= '0; m_count <= '0; m_exp_rd <= '0;
            m_new <= 1'b0; m_ovf <= 1'b0; m_freeze <= 1'b0;
            m_acked <= 1'b0; m_exp_ack <= 1'b0; m_rnw <= 1'b0;
            m_be3 <= 1'b0; m_w1 <= 1'b0; m_w0 <= 1'b0; m_idx <= 2'd0;
        end else begin
            if (m_cap) m_data <= ud;
            m_count  <= preload_req ? 32'hFFFF_FFFF : (m_cap ? m_count + 32'd1 : m_count);
            m_new    <= m_cap ? 1'b1 : (m_rd_clr ? 1'b0 : m_new);
            m_ovf    <= (m_cap && m_new) ? 1'b1 : (m_ovf_clr ? 1'b0 : m_ovf);
            m_freeze <= m_ctrl_wr ? m_w0 : m_freeze;
            m_exp_ack <= m_start;
            if (m_start) begin
                m_acked  <= 1'b1;
                m_rnw    <= rnw;
                m_idx    <= a_idx;
                m_be3    <= be[3];
                m_w1     <= dbus[30];
                m_w0     <= dbus[31];
                m_exp_rd <= word_view(a_idx);
            end else if (!sel) begin
                m_acked <= 1'b0;
            end
        end
    end

    // Every-cycle compare of the bus outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("xferAck", {31'd0, sl_ack}, {31'd0, m_exp_ack});
            check("Sl_DBus", bus2reg(sl_dbus), (m_exp_ack && m_rnw) ? m_exp_rd : 32'd0);
            check("tied_outputs", {29'd0, sl_err, sl_retry, sl_tout}, 32'd0);
        end
    end

    // driver tasks
    task automatic xfer(input logic [31:0] addr, input logic is_rd, input logic [31:0] wdata,
                        input logic [0:3] be_v, input logic cap_en, input logic [31:0] cap_val,
                        output logic [31:0] rdata);
        abus = addr;
        rnw  = is_rd;
        dbus = reg2bus(wdata);
        be   = be_v;
        sel  = 1'b1;
        @(negedge clk);
        check("ack_latency", {31'd0, sl_ack}, 32'd1);
        rdata = bus2reg(sl_dbus);
        sel  = 1'b0;
        rnw  = 1'b0;
        dbus = '0;
        if (cap_en) begin
            uv = 1'b1;
            ud = cap_val;
        end
        @(negedge clk);
        uv = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        xfer(addr, 1'b1, 32'd0, 4'b1111, 1'b0, 32'd0, d);
        check(name, d, exp);
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] wdata, input logic [0:3] be_v);
        logic [31:0] d;
        xfer(addr, 1'b0, wdata, be_v, 1'b0, 32'd0, d);
    endtask

    task automatic capture(input logic [31:0] v);
        uv = 1'b1;
        ud = v;
        @(negedge clk);
        uv = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int acks;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);

        // reset values of all four words
        rd_word("rst_data",   BASE + 32'h0, 32'h0);
        rd_word("rst_status", BASE + 32'h4, 32'h0);
        rd_word("rst_ctrl",   BASE + 32'h8, 32'h0);
        rd_word("rst_count",  BASE + 32'hC, 32'h0);

        // single capture; STATUS read through an alias of word 1
        capture(32'hDEAD_BEEF);
        rd_word("t2_status_alias", BASE + 32'h34, 32'h1);
        rd_word("t2_data",         BASE + 32'h0,  32'hDEAD_BEEF);
        rd_word("t2_status_clr",   BASE + 32'h4,  32'h0);
        rd_word("t2_count",        BASE + 32'hC,  32'h1);

        // overflow and W1C
        capture(32'h11);
        capture(32'h22);
        rd_word("t3_status_ovf", BASE + 32'h4, 32'h3);
        wr_word(BASE + 32'h4, 32'h2, 4'b1111);
        rd_word("t3_status_w1c", BASE + 32'h4, 32'h1);
        rd_word("t3_data",       BASE + 32'h0, 32'h22);

        // freeze, RO write, partial-BE write
        wr_word(BASE + 32'h8, 32'h1, 4'b0001);
        capture(32'h55);
        wr_word(BASE + 32'h0, 32'h1234_5678, 4'b1111);
        rd_word("t4_data_frozen",  BASE + 32'h0, 32'h22);
        rd_word("t4_count_frozen", BASE + 32'hC, 32'h3);
        rd_word("t4_status",       BASE + 32'h4, 32'h4);
        wr_word(BASE + 32'h8, 32'h0, 4'b1110);
        rd_word("t4_ctrl_be",      BASE + 32'h8, 32'h1);
        wr_word(BASE + 32'h8, 32'h0, 4'b1111);
        rd_word("t4_unfrozen",     BASE + 32'h4, 32'h0);

        // capture colliding with a DATA-read ack, then with an OVF clear
        capture(32'h66);
        xfer(BASE + 32'h0, 1'b1, 32'd0, 4'b1111, 1'b1, 32'h77, d);
        check("t5_data_old", d, 32'h66);
        rd_word("t5_status_new", BASE + 32'h4, 32'h3);
        xfer(BASE + 32'h4, 1'b0, 32'h2, 4'b1111, 1'b1, 32'h88, d);
        rd_word("t5_ovf_set_wins", BASE + 32'h4, 32'h3);
        rd_word("t5_data_new",     BASE + 32'h0, 32'h88);
        rd_word("t5_status_after", BASE + 32'h4, 32'h2);
        wr_word(BASE + 32'h4, 32'h2, 4'b1111);
        rd_word("t5_status_clear", BASE + 32'h4, 32'h0);
        rd_word("t5_count",        BASE + 32'hC, 32'h6);

        // counter wrap
        force dut.count_q = 32'hFFFF_FFFF;
        preload_req = 1'b1;
        @(negedge clk);
        release dut.count_q;
        preload_req = 1'b0;
        rd_word("t6_count_max", BASE + 32'hC, 32'hFFFF_FFFF);
        capture(32'hAB);
        rd_word("t6_count_wrap", BASE + 32'hC, 32'h0);

        // select held for 5 cycles -> one ack
        abus = BASE + 32'h8; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            acks += int'(sl_ack);
        end
        sel = 1'b0;
        check("t6_one_ack", acks, 1);
        repeat (2) @(negedge clk);

        // addresses outside the window
        abus = BASE + 32'h100; sel = 1'b1; acks = 0;
        repeat (3) begin
            @(negedge clk);
            acks += int'(sl_ack);
        end
        abus = BASE - 32'h4;
        repeat (3) begin
            @(negedge clk);
            acks += int'(sl_ack);
        end
        sel = 1'b0;
        check("miss_no_ack", acks, 0);
        repeat (2) @(negedge clk);

        // reset while in WAIT
        abus = BASE; rnw = 1'b1; sel = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; acks = 0;
        repeat (2) begin
            @(negedge clk);
            acks += int'(sl_ack);
        end
        rst = 1'b0; sel = 1'b0;
        check("rst_wait_no_ack", acks, 0);
        @(negedge clk);
        rd_word("post_rst_count",  BASE + 32'hC, 32'h0);
        rd_word("post_rst_status", BASE + 32'h4, 32'h0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
